// File: rtl/rocc_mem_responder.sv
// rocc_mem_responder
//   Memory-side responder for a RoCC accelerator memory port. Requests are
//   served from an internal scratchpad of 64-bit words. Each request produces
//   exactly one response strobe LATENCY cycles later, in acceptance order,
//   unless a reset intervenes.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   mem_req_ready_o              request may be accepted this cycle
//   mem_req_valid_i              request valid
//   mem_req_addr_i   [39:0]      byte address
//   mem_req_tag_i    [9:0]       tag echoed in the response
//   mem_req_cmd_i    [4:0]       0 = load (M_XRD), 1 = store (M_XWR)
//   mem_req_typ_i    [2:0]       B,H,W,D,BU,HU,WU (0..6)
//   mem_req_phys_i               unused
//   mem_req_data_i   [63:0]      right-aligned store data
//   mem_resp_valid_o             one-cycle response strobe (no back-pressure)
//   mem_resp_addr_o/tag_o/cmd_o/typ_o   request echo
//   mem_resp_data_o  [63:0]      extended load result, 0 otherwise
//   mem_resp_has_data_o          successful load
//   mem_resp_data_word_bypass_o  raw word of a successful load, 0 otherwise
//   mem_resp_store_data_o        store data of a successful store, 0 otherwise
//   mem_resp_nack_o              request rejected, memory untouched
//   mem_resp_replay_o            always 0
module rocc_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_ready_o,
  input  logic        mem_req_valid_i,
  input  logic [39:0] mem_req_addr_i,
  input  logic [9:0]  mem_req_tag_i,
  input  logic [4:0]  mem_req_cmd_i,
  input  logic [2:0]  mem_req_typ_i,
  input  logic        mem_req_phys_i,
  input  logic [63:0] mem_req_data_i,
  output logic        mem_resp_valid_o,
  output logic [39:0] mem_resp_addr_o,
  output logic [9:0]  mem_resp_tag_o,
  output logic [4:0]  mem_resp_cmd_o,
  output logic [2:0]  mem_resp_typ_o,
  output logic [63:0] mem_resp_data_o,
  output logic        mem_resp_has_data_o,
  output logic [63:0] mem_resp_data_word_bypass_o,
  output logic [63:0] mem_resp_store_data_o,
  output logic        mem_resp_nack_o,
  output logic        mem_resp_replay_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;

  typedef struct packed {
    logic [39:0] addr;
    logic [9:0]  tag;
    logic [4:0]  cmd;
    logic [2:0]  typ;
    logic        nack;
    logic        load_ok;
    logic [63:0] store_data;
  } resp_t;

  // Physical-address flag carries no meaning for a flat scratchpad.
  logic unused_phys;
  assign unused_phys = mem_req_phys_i;

  // Warm-up register: ready stays low for one cycle after reset releases.
  logic warm_reg;
  always_ff @(posedge clk) begin
    if (rst) warm_reg <= 1'b0;
    else     warm_reg <= 1'b1;
  end

  assign mem_req_ready_o = warm_reg & ~rst;

  logic          accept;
  logic [AW-1:0] idx;
  logic [2:0]    lane;
  logic          out_of_range;
  logic          bad_cmd;
  logic          misaligned;
  logic          nack;
  logic          load_ok;
  logic          store_ok;
  logic [3:0]    nbytes;
  logic [7:0]    be;
  logic [63:0]   wdata;
  resp_t         req_resp;

  assign accept       = mem_req_valid_i & mem_req_ready_o;
  assign idx          = mem_req_addr_i[3+AW-1:3];
  assign lane         = mem_req_addr_i[2:0];
  assign out_of_range = |mem_req_addr_i[39:3+AW];
  assign bad_cmd      = (mem_req_cmd_i != M_XRD) && (mem_req_cmd_i != M_XWR);

  always_comb begin
    misaligned = 1'b0;
    case (mem_req_typ_i)
      3'd1, 3'd5: misaligned = mem_req_addr_i[0];
      3'd2, 3'd6: misaligned = |mem_req_addr_i[1:0];
      3'd3:       misaligned = |mem_req_addr_i[2:0];
      default:    misaligned = 1'b0;
    endcase
  end

  assign nack     = out_of_range | bad_cmd | (mem_req_typ_i == 3'd7) | misaligned;
  assign load_ok  = (mem_req_cmd_i == M_XRD) & ~nack;
  assign store_ok = (mem_req_cmd_i == M_XWR) & ~nack;

  // Alignment checks guarantee lane + nbytes never exceeds 8 for an accepted store.
  assign nbytes = 4'd1 << mem_req_typ_i[1:0];
  assign wdata  = mem_req_data_i << {lane, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_be
      localparam logic [3:0] LANE = 4'(gi);
      assign be[gi] = (LANE >= {1'b0, lane}) && (LANE < ({1'b0, lane} + nbytes));
    end
  endgenerate

  always_comb begin
    req_resp            = '0;
    req_resp.addr       = mem_req_addr_i;
    req_resp.tag        = mem_req_tag_i;
    req_resp.cmd        = mem_req_cmd_i;
    req_resp.typ        = mem_req_typ_i;
    req_resp.nack       = nack;
    req_resp.load_ok    = load_ok;
    req_resp.store_data = store_ok ? mem_req_data_i : 64'd0;
  end

  // Scratchpad; contents intentionally survive reset.
  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (accept && store_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Response pipeline. Valid bits shift every cycle; payload registers only
  // load behind a valid entry so the output fields hold between strobes.
  logic        stage_valid_reg [LATENCY];
  resp_t       stage_resp_reg  [LATENCY];
  logic [63:0] stage_word_reg  [LATENCY];

  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) begin
            stage_valid_reg[0] <= 1'b0;
            stage_resp_reg[0]  <= '0;
          end else begin
            stage_valid_reg[0] <= accept;
            if (accept) stage_resp_reg[0] <= req_resp;
          end
        end
        // Registered scratchpad read, captured at the acceptance edge.
        always_ff @(posedge clk) begin
          if (accept && load_ok) stage_word_reg[0] <= mem[idx];
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) begin
            stage_valid_reg[gi] <= 1'b0;
            stage_resp_reg[gi]  <= '0;
          end else begin
            stage_valid_reg[gi] <= stage_valid_reg[gi-1];
            if (stage_valid_reg[gi-1]) stage_resp_reg[gi] <= stage_resp_reg[gi-1];
          end
        end
        always_ff @(posedge clk) begin
          if (stage_valid_reg[gi-1]) stage_word_reg[gi] <= stage_word_reg[gi-1];
        end
      end
    end
  endgenerate

  resp_t       out_resp;
  logic [63:0] out_word;
  logic [63:0] shifted;
  logic [63:0] extended;

  assign out_resp = stage_resp_reg[LATENCY-1];
  assign out_word = stage_word_reg[LATENCY-1];
  assign shifted  = out_word >> {out_resp.addr[2:0], 3'b000};

  always_comb begin
    extended = '0;
    case (out_resp.typ)
      3'd0:    extended = {{56{shifted[7]}},  shifted[7:0]};
      3'd1:    extended = {{48{shifted[15]}}, shifted[15:0]};
      3'd2:    extended = {{32{shifted[31]}}, shifted[31:0]};
      3'd3:    extended = shifted;
      3'd4:    extended = {56'd0, shifted[7:0]};
      3'd5:    extended = {48'd0, shifted[15:0]};
      3'd6:    extended = {32'd0, shifted[31:0]};
      default: extended = '0;
    endcase
  end

  assign mem_resp_valid_o            = stage_valid_reg[LATENCY-1];
  assign mem_resp_addr_o             = out_resp.addr;
  assign mem_resp_tag_o              = out_resp.tag;
  assign mem_resp_cmd_o              = out_resp.cmd;
  assign mem_resp_typ_o              = out_resp.typ;
  assign mem_resp_nack_o             = out_resp.nack;
  assign mem_resp_has_data_o         = out_resp.load_ok;
  assign mem_resp_data_o             = out_resp.load_ok ? extended : 64'd0;
  assign mem_resp_data_word_bypass_o = out_resp.load_ok ? out_word : 64'd0;
  assign mem_resp_store_data_o       = out_resp.store_data;
  assign mem_resp_replay_o           = 1'b0;

endmodule

// File: doc/rocc_mem_responder.md
# rocc_mem_responder

Synthesizable memory-side responder for the RoCC accelerator memory port. It accepts `mem_req_*` requests from an accelerator such as `vv_add` and serves them from an internal 64-bit-word scratchpad. It returns `mem_resp_*` responses after a fixed latency. It is the far end of the accelerator's memory interface, used in RTL co-simulation and FPGA test builds in place of the L1 data cache.

## Interface
- `DEPTH`, 1024: number of 64-bit words in the scratchpad (power of two).
- `LATENCY`, 2: cycles from request acceptance to response (>= 1).
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `mem_req_ready_o` output 1: request can be accepted this cycle.
- `mem_req_valid_i` input 1: request valid.
- `mem_req_addr_i` input 40: byte address.
- `mem_req_tag_i` input 10: tag, echoed in the response.
- `mem_req_cmd_i` input 5: 5'b00000 is load (M_XRD); 5'b00001 is store (M_XWR).
- `mem_req_typ_i` input 3: 0 is B, 1 is H, 2 is W, 3 is D, 4 is BU, 5 is HU, 6 is WU.
- `mem_req_phys_i` input 1: ignored; echoed nowhere.
- `mem_req_data_i` input 64: store data, right-aligned (value in low bits).
- `mem_resp_valid_o` output 1: one-cycle response strobe; there is no ready, so the consumer must take it.
- `mem_resp_addr_o` output 40, `mem_resp_tag_o` output 10, `mem_resp_cmd_o` output 5, `mem_resp_typ_o` output 3: echo of the request.
- `mem_resp_data_o` output 64: load result, sign- or zero-extended; 0 for stores and nacks.
- `mem_resp_has_data_o` output 1: 1 only for a successful load.
- `mem_resp_data_word_bypass_o` output 64: raw 64-bit word read at the word address; 0 for stores and nacks.
- `mem_resp_store_data_o` output 64: `mem_req_data_i` of a store; 0 otherwise.
- `mem_resp_nack_o` output 1: request rejected; memory is unchanged.
- `mem_resp_replay_o` output 1: constant 0.

## Operation
- `mem_req_ready_o` is 0 in any cycle where `rst`=1. It is also 0 in the first cycle after `rst` deasserts (a one-cycle warm-up register). After that it is 1.
- A request is accepted on an edge where `valid`&`ready` are both high. At most one request is accepted per cycle.
- Word index is `addr[3+log2(DEPTH)-1:3]`. Byte lane is `addr[2:0]`.
- A request is nacked when any of the following holds:
  - `addr[39:3]` >= DEPTH (out of range);
  - `cmd` is not XRD or XWR;
  - `typ`=7;
  - misaligned: H/HU with `addr[0]`≠0, W/WU with `addr[1:0]`≠0, D with `addr[2:0]`≠0.
- Store: at the acceptance edge, the low 2^(typ&3) bytes of `data_i` are written into the lanes starting at `addr[2:0]`. Other bytes of the word are preserved.
- Load: the word is read at the acceptance edge, so it reflects all earlier-accepted stores. The addressed field is extracted and extended: B/H/W/D sign-extend; BU/HU/WU zero-extend.
- A store followed by a load to the same word on the next cycle returns the new data.
- The response pipeline is a LATENCY-deep shift register of {valid, fields}. Responses leave in acceptance order.
- Scratchpad contents are not cleared by reset. The bench must write before reading.

## Timing
- Request accepted at edge N gives `mem_resp_valid_o`=1 during the cycle after edge N+LATENCY-1. With LATENCY=2, the response is visible 2 cycles after the request cycle.
- Back-to-back accepted requests produce back-to-back response strobes with no gaps.
- Throughput is one request per cycle. No internal back-pressure exists after warm-up.
- Reset values:
  - all `mem_resp_*` outputs are 0;
  - `mem_req_ready_o` is 0;
  - pipeline valid bits are cleared.
- Reset mid-operation: in-flight responses are dropped and never emitted. A store accepted before the reset edge has already written the scratchpad and stays written.
- Response fields other than `valid` hold their last values when `valid`=0. Consumers must ignore them.

## Test plan
- Reset, then store D 0x1122334455667788 at addr 0x40, then load D at 0x40. Required: load response has `data`=0x1122334455667788, `has_data`=1, tag echoed. The store response has `has_data`=0 and `store_data`=0x1122334455667788.
- With word 0x40 holding 0x1122334455667788, load B at 0x47 gives `data`=0x0000000000000011. Store B 0x80 at 0x47, then load B at 0x47 gives 0xFFFFFFFFFFFFFF80. Load BU at 0x47 gives 0x80, and `data_word_bypass`=0x8022334455667788.
- Load H at 0x41 gives nack=1, has_data=0, data=0. Load D at byte address DEPTH*8 gives nack. A store with cmd=5'b00011 gives nack and the memory word is unchanged.
- Issue 8 back-to-back requests with tags 0..7. Required: 8 consecutive response strobes with tags 0..7 in order, the first exactly LATENCY cycles after the first request.
- Assert `rst` for 1 cycle while 2 responses are in flight. Required: no `mem_resp_valid_o` afterwards, `mem_req_ready_o`=0 for the reset cycle plus 1 cycle, then 1.
- Store W 0xDEADBEEF at 0x104, then load W at 0x104 gives 0xFFFFFFFFDEADBEEF. Load WU at 0x104 gives 0x00000000DEADBEEF. Load W at 0x100 returns the preserved lower half of the word.
